// File: rtl/ecc_dup_chk_if.sv
// Beat-level bus of the lockstep ECC checker: codeword input stream and checked-data output stream.
// A beat moves on a clock edge where valid and ready are both high; a source holds its payload
// and valid steady until that edge, and ready may depend combinationally on the downstream ready.
interface ecc_dup_chk_if #(
  parameter int DATA_WIDTH   = 123,
  parameter int PARITY_WIDTH = 9
);
  logic                    in_vld;
  logic                    in_rdy;
  logic [DATA_WIDTH-1:0]   data_in;
  logic [PARITY_WIDTH-1:0] parity_in;
  logic                    bypass;
  logic                    fault_detc_en;
  logic                    out_vld;
  logic                    out_rdy;
  logic [DATA_WIDTH-1:0]   data_out;
  logic                    sbit_err;
  logic                    dbit_err;
  logic                    ecc_fault;

  modport master (
    output in_vld, data_in, parity_in, bypass, fault_detc_en, out_rdy,
    input  in_rdy, out_vld, data_out, sbit_err, dbit_err, ecc_fault
  );

  modport slave (
    input  in_vld, data_in, parity_in, bypass, fault_detc_en, out_rdy,
    output in_rdy, out_vld, data_out, sbit_err, dbit_err, ecc_fault
  );
endinterface

// File: rtl/ecc_dup_chk_pipe.sv
// Lockstep SECDED checker: two identical decoders on each beat, outputs compared, 2-stage
// valid/ready pipeline with saturating event counters, sticky fault flag and one-shot injection.
module ecc_cal #(
  parameter int DATA_WIDTH   = 123,
  parameter int PARITY_WIDTH = 9
) (
  input  logic [DATA_WIDTH-1:0]   data,
  input  logic [PARITY_WIDTH-1:0] parity,
  input  logic                    bypass,
  output logic                    sbit,
  output logic                    dbit,
  output logic [DATA_WIDTH-1:0]   mask
);
  localparam int HB = PARITY_WIDTH - 1;

  // Hamming positions of the data bits: every non-power-of-two index from 3 upward.
  function automatic logic [DATA_WIDTH*HB-1:0] build_pos();
    logic [DATA_WIDTH*HB-1:0] v;
    int n;
    v = '0;
    n = 0;
    for (int q = 3; q < (1 << HB); q++) begin
      if (((q & (q - 1)) != 0) && (n < DATA_WIDTH)) begin
        v[n*HB +: HB] = q[HB-1:0];
        n++;
      end
    end
    return v;
  endfunction

  localparam logic [DATA_WIDTH*HB-1:0] POS = build_pos();

  logic [HB-1:0] syn;
  logic          overall;

  always_comb begin
    syn = parity[HB-1:0];
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (data[i]) syn = syn ^ POS[i*HB +: HB];
    end
  end

  // Top parity bit covers the whole codeword, so an odd overall count means a single error.
  assign overall = ^{data, parity};
  assign sbit    = ~bypass & overall;
  assign dbit    = ~bypass & ~overall & (syn != '0);

  always_comb begin
    mask = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      mask[i] = sbit & (syn == POS[i*HB +: HB]);
    end
  end
endmodule

module ecc_dup_chk_pipe #(
  parameter int DATA_WIDTH   = 123,
  parameter int PARITY_WIDTH = 9,
  parameter int CNT_WIDTH    = 16,
  parameter int IDX_WIDTH    = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  ecc_dup_chk_if.slave         bus,
  input  logic                 inj_req,
  input  logic [IDX_WIDTH-1:0] inj_bit,
  output logic                 inj_busy,
  input  logic                 cnt_clr,
  output logic [CNT_WIDTH-1:0] sbit_cnt,
  output logic [CNT_WIDTH-1:0] dbit_cnt,
  output logic [CNT_WIDTH-1:0] fault_cnt,
  output logic                 fault_sticky
);
  localparam logic [DATA_WIDTH-1:0] ONE_HOT0 = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic                    s1_vld, s1_bypass, s1_fde, s1_inj;
  logic [DATA_WIDTH-1:0]   s1_data;
  logic [PARITY_WIDTH-1:0] s1_parity;
  logic [IDX_WIDTH-1:0]    s1_inj_bit, inj_bit_q;
  logic                    out_vld_q, sbit_q, dbit_q, fault_q;
  logic [DATA_WIDTH-1:0]   data_out_q;
  logic                    adv, in_rdy_c, accept, s2_load, xfer;
  logic                    sb0, db0, sb1, db1, match, fault_c;
  logic [DATA_WIDTH-1:0]   m0, m1, d1_data, dec0_data;

  assign adv      = ~out_vld_q | bus.out_rdy;
  assign in_rdy_c = ~s1_vld | adv;
  assign accept   = bus.in_vld & in_rdy_c;
  assign s2_load  = s1_vld & adv;
  assign xfer     = out_vld_q & bus.out_rdy;

  assign bus.in_rdy    = in_rdy_c;
  assign bus.out_vld   = out_vld_q;
  assign bus.data_out  = data_out_q;
  assign bus.sbit_err  = sbit_q;
  assign bus.dbit_err  = dbit_q;
  assign bus.ecc_fault = fault_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      inj_busy  <= 1'b0;
      inj_bit_q <= '0;
    end else if (inj_busy) begin
      if (accept) inj_busy <= 1'b0;
    end else if (inj_req) begin
      inj_busy  <= 1'b1;
      inj_bit_q <= inj_bit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld     <= 1'b0;
      s1_data    <= '0;
      s1_parity  <= '0;
      s1_bypass  <= 1'b0;
      s1_fde     <= 1'b0;
      s1_inj     <= 1'b0;
      s1_inj_bit <= '0;
    end else if (accept) begin
      s1_vld     <= 1'b1;
      s1_data    <= bus.data_in;
      s1_parity  <= bus.parity_in;
      s1_bypass  <= bus.bypass;
      s1_fde     <= bus.fault_detc_en;
      s1_inj     <= inj_busy;
      s1_inj_bit <= inj_bit_q;
    end else if (s2_load) begin
      s1_vld <= 1'b0;
    end
  end

  // An out-of-range index shifts the one-hot past the top bit, so nothing is flipped.
  assign d1_data = s1_inj ? (s1_data ^ (ONE_HOT0 << s1_inj_bit)) : s1_data;

  ecc_cal #(.DATA_WIDTH(DATA_WIDTH), .PARITY_WIDTH(PARITY_WIDTH)) u_dec0 (
    .data(s1_data), .parity(s1_parity), .bypass(s1_bypass), .sbit(sb0), .dbit(db0), .mask(m0)
  );

  ecc_cal #(.DATA_WIDTH(DATA_WIDTH), .PARITY_WIDTH(PARITY_WIDTH)) u_dec1 (
    .data(d1_data), .parity(s1_parity), .bypass(s1_bypass), .sbit(sb1), .dbit(db1), .mask(m1)
  );

  assign match     = ({sb0, db0, m0} == {sb1, db1, m1});
  assign dec0_data = s1_data ^ m0;
  assign fault_c   = ~match & s1_fde;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld_q  <= 1'b0;
      data_out_q <= '0;
      sbit_q     <= 1'b0;
      dbit_q     <= 1'b0;
      fault_q    <= 1'b0;
    end else if (s2_load) begin
      out_vld_q  <= 1'b1;
      data_out_q <= fault_c ? s1_data : dec0_data;
      sbit_q     <= sb0;
      dbit_q     <= db0;
      fault_q    <= fault_c;
    end else if (bus.out_rdy) begin
      out_vld_q <= 1'b0;
    end
  end

  // A clear that lands on a counted transfer keeps that event instead of losing it.
  function automatic logic [CNT_WIDTH-1:0] sat_next(input logic [CNT_WIDTH-1:0] cur,
                                                    input logic inc, input logic clr);
    if (clr)               return inc ? CNT_ONE : '0;
    else if (inc && ~&cur) return cur + CNT_ONE;
    else                   return cur;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      sbit_cnt     <= '0;
      dbit_cnt     <= '0;
      fault_cnt    <= '0;
      fault_sticky <= 1'b0;
    end else begin
      sbit_cnt  <= sat_next(sbit_cnt,  xfer & sbit_q,  cnt_clr);
      dbit_cnt  <= sat_next(dbit_cnt,  xfer & dbit_q,  cnt_clr);
      fault_cnt <= sat_next(fault_cnt, xfer & fault_q, cnt_clr);
      if (cnt_clr)              fault_sticky <= xfer & fault_q;
      else if (xfer & fault_q)  fault_sticky <= 1'b1;
    end
  end
endmodule

// File: tb/tb_ecc_dup_chk_pipe.sv
// Directed bench for ecc_dup_chk_pipe: driver tasks push expected beats into a queue and a
// negedge monitor pops and compares every output transfer.
module tb_ecc_dup_chk_pipe;
  localparam int DW = 123, PW = 9, CW = 16, IW = 7, EW = DW + 3;

  localparam logic [DW-1:0] D_A = 123'h5A5A_1234_5678_9ABC_DEF0_1357_9BDF_024;
  localparam logic [DW-1:0] D_B = '0;
  localparam logic [DW-1:0] D_C = '1;
  localparam logic [DW-1:0] D_D = 123'h2F00_00C3_0000_0000_0000_FFFF_0001_ABC;

  logic          clk = 1'b0;
  logic          rst;
  logic          inj_req, inj_busy, cnt_clr, fault_sticky;
  logic [IW-1:0] inj_bit;
  logic [CW-1:0] sbit_cnt, dbit_cnt, fault_cnt;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;
  int            tests = 0;
  int            fails = 0;

  ecc_dup_chk_if #(.DATA_WIDTH(DW), .PARITY_WIDTH(PW)) bus ();

  ecc_dup_chk_pipe #(.DATA_WIDTH(DW), .PARITY_WIDTH(PW), .CNT_WIDTH(CW), .IDX_WIDTH(IW)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .inj_req(inj_req), .inj_bit(inj_bit), .inj_busy(inj_busy),
    .cnt_clr(cnt_clr), .sbit_cnt(sbit_cnt), .dbit_cnt(dbit_cnt), .fault_cnt(fault_cnt),
    .fault_sticky(fault_sticky)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Encoder: data fills the non-power-of-two positions from 3 up; top bit is overall parity.
  function automatic logic [PW-1:0] enc(input logic [DW-1:0] d);
    logic [PW-1:0] p;
    int pos;
    p = '0;
    pos = 2;
    for (int i = 0; i < DW; i++) begin
      pos++;
      while ((pos & (pos - 1)) == 0) pos++;
      for (int j = 0; j < PW - 1; j++)
        if (pos[j] && d[i]) p[j] = ~p[j];
    end
    p[PW-1] = ^{d, p[PW-2:0]};
    return p;
  endfunction

  function automatic logic [DW-1:0] bitv(input int i);
    logic [DW-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [EW-1:0] ew(input logic [DW-1:0] d, input logic s, input logic db,
                                       input logic f);
    return {d, s, db, f};
  endfunction

  // ---------------- driver tasks (called just after a rising edge) ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic [PW-1:0] p, input logic byp,
                      input logic fde, input logic [EW-1:0] e);
    int g = 0;
    bus.in_vld = 1'b1;
    bus.data_in = d;
    bus.parity_in = p;
    bus.bypass = byp;
    bus.fault_detc_en = fde;
    @(negedge clk);
    while (!bus.in_rdy && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (!bus.in_rdy) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: in_rdy stayed 0 for %0d cycles, required 1", g);
      bus.in_vld = 1'b0;
      return;
    end
    @(posedge clk);
    exp_q.push_back(e);
    #1 bus.in_vld = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while (exp_q.size() != 0 && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d beats outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    step();
  endtask

  task automatic wait_vld();
    int g = 0;
    @(negedge clk);
    while (!bus.out_vld && g < 20) begin
      @(negedge clk);
      g++;
    end
    if (!bus.out_vld) begin
      tests++;
      fails++;
      $display("FAIL wait_vld: out_vld stayed 0, required 1");
    end
  endtask

  task automatic arm(input logic [IW-1:0] b);
    inj_bit = b;
    inj_req = 1'b1;
    step();
    inj_req = 1'b0;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst && bus.out_vld && bus.out_rdy) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL extra_beat: got data %h with no beat pending, required none", bus.data_out);
      end else begin
        mon_e = exp_q.pop_front();
        chk("beat", {bus.data_out, bus.sbit_err, bus.dbit_err, bus.ecc_fault}, mon_e);
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    inj_req = 1'b0;
    inj_bit = '0;
    cnt_clr = 1'b0;
    bus.in_vld = 1'b0;
    bus.data_in = '0;
    bus.parity_in = '0;
    bus.bypass = 1'b0;
    bus.fault_detc_en = 1'b0;
    bus.out_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_vld", bus.out_vld, 0);
    chk("rst_in_rdy", bus.in_rdy, 1);
    chk("rst_data_out", bus.data_out, 0);
    chk("rst_flags", {bus.sbit_err, bus.dbit_err, bus.ecc_fault}, 0);
    chk("rst_inj_busy", inj_busy, 0);
    chk("rst_cnts", {sbit_cnt, dbit_cnt, fault_cnt, fault_sticky}, 0);
    step();

    // clean beat and latency
    send(D_A, enc(D_A), 1'b0, 1'b1, ew(D_A, 0, 0, 0));
    @(negedge clk);
    chk("lat_edge_n", bus.out_vld, 0);
    @(negedge clk);
    chk("lat_edge_n1", bus.out_vld, 1);
    drain();
    chk("clean_cnts", {sbit_cnt, dbit_cnt, fault_cnt, fault_sticky}, 0);

    // single-bit errors: data bits 5, 0, 122 and parity bit 3
    send(D_A ^ bitv(5),   enc(D_A),           1'b0, 1'b1, ew(D_A, 1, 0, 0));
    send(D_C ^ bitv(0),   enc(D_C),           1'b0, 1'b1, ew(D_C, 1, 0, 0));
    send(D_D ^ bitv(122), enc(D_D),           1'b0, 1'b1, ew(D_D, 1, 0, 0));
    send(D_B,             enc(D_B) ^ 9'h008,  1'b0, 1'b1, ew(D_B, 1, 0, 0));
    drain();
    chk("sbit_cnt_4", sbit_cnt, 4);
    chk("fault_cnt_0", fault_cnt, 0);

    // double-bit error passes through uncorrected
    send(D_A ^ bitv(5) ^ bitv(6), enc(D_A), 1'b0, 1'b1, ew(D_A ^ bitv(5) ^ bitv(6), 0, 1, 0));
    drain();
    chk("dbit_cnt_1", dbit_cnt, 1);

    // bypass: raw data, no flags, even with a corrupted bit
    send(D_A ^ bitv(5), enc(D_A), 1'b1, 1'b1, ew(D_A ^ bitv(5), 0, 0, 0));

    // injection on a clean beat
    arm(7'd10);
    chk("inj_busy_armed", inj_busy, 1);
    send(D_D, enc(D_D), 1'b0, 1'b1, ew(D_D, 0, 0, 1));
    chk("inj_busy_clear", inj_busy, 0);
    drain();
    chk("fault_cnt_1", fault_cnt, 1);
    chk("sticky_set", fault_sticky, 1);

    // injection on an sbit beat: decoders disagree, raw data forwarded
    arm(7'd10);
    send(D_A ^ bitv(5), enc(D_A), 1'b0, 1'b1, ew(D_A ^ bitv(5), 1, 0, 1));
    // same with detection disabled: corrected data, no fault
    arm(7'd10);
    send(D_A ^ bitv(5), enc(D_A), 1'b0, 1'b0, ew(D_A, 1, 0, 0));
    // out-of-range index flips nothing
    arm(7'd127);
    send(D_C, enc(D_C), 1'b0, 1'b1, ew(D_C, 0, 0, 0));
    // request coincident with an accept applies to the following beat
    inj_bit = 7'd20;
    inj_req = 1'b1;
    send(D_B, enc(D_B), 1'b0, 1'b1, ew(D_B, 0, 0, 0));
    inj_req = 1'b0;
    chk("inj_busy_next", inj_busy, 1);
    send(D_B, enc(D_B), 1'b0, 1'b1, ew(D_B, 0, 0, 1));
    drain();
    chk("sbit_cnt_6", sbit_cnt, 6);
    chk("fault_cnt_3", fault_cnt, 3);

    // back-pressure mid-stream
    fork
      begin
        send(D_A,          enc(D_A), 1'b0, 1'b1, ew(D_A, 0, 0, 0));
        send(D_B,          enc(D_B), 1'b0, 1'b1, ew(D_B, 0, 0, 0));
        send(D_C ^ bitv(0), enc(D_C), 1'b0, 1'b1, ew(D_C, 1, 0, 0));
        send(D_D,          enc(D_D), 1'b0, 1'b1, ew(D_D, 0, 0, 0));
      end
      begin
        @(posedge clk);
        #1 bus.out_rdy = 1'b0;
        repeat (3) @(negedge clk);
        chk("bp_in_rdy", bus.in_rdy, 0);
        chk("bp_out_vld", bus.out_vld, 1);
        chk("bp_hold_data", bus.data_out, D_A);
        step();
        bus.out_rdy = 1'b1;
      end
    join
    drain();
    chk("bp_sbit_cnt", sbit_cnt, 7);

    // clear with no transfer
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("clr_cnts", {sbit_cnt, dbit_cnt, fault_cnt, fault_sticky}, 0);

    // saturation
    for (int i = 0; i < 65535; i++) send(bitv(7), '0, 1'b0, 1'b1, ew('0, 1, 0, 0));
    drain();
    chk("sat_ffff", sbit_cnt, 16'hFFFF);
    send(bitv(7), '0, 1'b0, 1'b1, ew('0, 1, 0, 0));
    send(bitv(7), '0, 1'b0, 1'b1, ew('0, 1, 0, 0));
    drain();
    chk("sat_hold", sbit_cnt, 16'hFFFF);

    // clear coincident with an sbit transfer
    bus.out_rdy = 1'b0;
    send(bitv(7), '0, 1'b0, 1'b1, ew('0, 1, 0, 0));
    wait_vld();
    step();
    bus.out_rdy = 1'b1;
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("clr_sbit_keep", sbit_cnt, 1);

    // clear coincident with a fault transfer
    arm(7'd10);
    bus.out_rdy = 1'b0;
    send(D_A, enc(D_A), 1'b0, 1'b1, ew(D_A, 0, 0, 1));
    wait_vld();
    step();
    bus.out_rdy = 1'b1;
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("clr_fault_keep", fault_cnt, 1);
    chk("clr_sticky_keep", fault_sticky, 1);
    chk("clr_sbit_zero", sbit_cnt, 0);

    // reset with both stages full and injection armed
    bus.out_rdy = 1'b0;
    send(D_A, enc(D_A), 1'b0, 1'b1, ew(D_A, 0, 0, 0));
    send(D_B, enc(D_B), 1'b0, 1'b1, ew(D_B, 0, 0, 0));
    arm(7'd3);
    chk("full_in_rdy", bus.in_rdy, 0);
    chk("full_inj_busy", inj_busy, 1);
    rst = 1'b1;
    bus.out_rdy = 1'b1;
    exp_q.delete();
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_out_vld", bus.out_vld, 0);
    chk("mrst_inj_busy", inj_busy, 0);
    chk("mrst_in_rdy", bus.in_rdy, 1);
    chk("mrst_cnts", {sbit_cnt, dbit_cnt, fault_cnt, fault_sticky}, 0);

    step();
    chk("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
